seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier_if.sv | 23 ++
 rtl/seq_multiplier.sv | 85 ++++++++
 tb/tb_seq_multiplier.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Operand/product handshake bundle for seq_multiplier.
// The master drives operands and out_ready; the slave returns in_ready and the product.
interface seq_multiplier_if #(
    parameter int N = 32
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] p;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p
    );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative unsigned multiplier: K multiplier bits per cycle, N/K cycles per product.
// Valid/ready on both operand and product sides; product held under backpressure.
module seq_multiplier #(
    parameter int N = 32,
    parameter int K = 1
) (
    input  logic            clk,
    input  logic            rst,
    seq_multiplier_if.slave bus
);
    localparam int ITER = N / K;
    localparam int CW   = $clog2(ITER + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if (N < 2 || K < 1 || K > N || (N % K) != 0) begin : g_bad_param
        $error("seq_multiplier: illegal N/K combination");
    end

    logic [1:0]     state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [2*N-1:0] b_q, b_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] pp;

    // a_q shifts right and b_q left each step, so the low K bits of a_q
    // always select the digit whose weight b_q already carries.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        pp      = {{(2*N-K){1'b0}}, a_q[K-1:0]} * b_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = {{N{1'b0}}, bus.b};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d = acc_q + pp;
                a_d   = a_q >> K;
                b_d   = b_q << K;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && !rst;
    assign bus.out_valid = (state_q == S_DONE) && !rst;
    assign bus.p         = rst ? '0 : acc_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized and directed bench for seq_multiplier across several N/K builds.
// One driver bus is steered to the build selected by cur.
module tb_seq_multiplier;
    localparam int NB = 9;

    function automatic int n_of(int g);
        return (g < 3) ? 8 : 32;
    endfunction

    function automatic int k_of(int g);
        case (g)
            0: return 1;
            1: return 4;
            2: return 8;
            3: return 1;
            4: return 2;
            5: return 4;
            6: return 8;
            7: return 16;
            default: return 32;
        endcase
    endfunction

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_drv;
    logic [31:0] b_drv;
    int          cur;
    logic [NB-1:0] rdy_v;
    logic [NB-1:0] ov_v;
    logic [63:0]   p_v [NB];

    int checks;
    int errors;

    for (genvar g = 0; g < NB; g++) begin : g_dut
        localparam int NN = n_of(g);
        localparam int KK = k_of(g);
        seq_multiplier_if #(.N(NN)) bus ();
        seq_multiplier #(.N(NN), .K(KK)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );
        assign bus.in_valid  = in_valid && (cur == g);
        assign bus.a         = a_drv[NN-1:0];
        assign bus.b         = b_drv[NN-1:0];
        assign bus.out_ready = out_ready;
        assign rdy_v[g]      = bus.in_ready;
        assign ov_v[g]       = bus.out_valid;
        assign p_v[g]        = 64'(bus.p);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: product of the masked operands, ready after N/K busy cycles.
    task automatic do_op(input logic [31:0] ai, input logic [31:0] bi,
                         input int bp, input bit spam);
        int n;
        int it;
        int lat;
        logic [63:0] mask;
        logic [63:0] exp_p;
        logic [63:0] held;
        n     = n_of(cur);
        it    = n / k_of(cur);
        mask  = (64'd1 << n) - 64'd1;
        exp_p = (64'(ai) & mask) * (64'(bi) & mask);
        checks++;
        if (rdy_v[cur] !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready dut%0d got %b want 1", cur, rdy_v[cur]);
        end
        in_valid  = 1'b1;
        a_drv     = ai;
        b_drv     = bi;
        out_ready = 1'($urandom % 2);
        @(posedge clk);
        @(negedge clk);
        if (spam) begin
            a_drv = 32'hFFFF_FFFF;
            b_drv = 32'hFFFF_FFFF;
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (lat < 200 && ov_v[cur] !== 1'b1) begin
            checks++;
            if (rdy_v[cur] !== 1'b0) begin
                errors++;
                $display("FAIL busy_ready dut%0d got %b want 0", cur, rdy_v[cur]);
            end
            out_ready = 1'($urandom % 2);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (lat != it) begin
            errors++;
            $display("FAIL latency dut%0d got %0d want %0d", cur, lat, it);
        end
        checks++;
        if (p_v[cur] !== exp_p) begin
            errors++;
            $display("FAIL product dut%0d a=%0h b=%0h got %0h want %0h",
                     cur, ai, bi, p_v[cur], exp_p);
        end
        held = p_v[cur];
        for (int c = 0; c < bp; c++) begin
            out_ready = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ov_v[cur] !== 1'b1 || p_v[cur] !== held || rdy_v[cur] !== 1'b0) begin
                errors++;
                $display("FAIL hold dut%0d got ov=%b p=%0h rdy=%b want ov=1 p=%0h rdy=0",
                         cur, ov_v[cur], p_v[cur], rdy_v[cur], held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ov_v[cur] !== 1'b0 || rdy_v[cur] !== 1'b1) begin
            errors++;
            $display("FAIL to_idle dut%0d got ov=%b rdy=%b want ov=0 rdy=1",
                     cur, ov_v[cur], rdy_v[cur]);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a_drv     = 32'd7;
        b_drv     = 32'd9;
        cur       = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NB; g++) begin
            checks++;
            if (rdy_v[g] !== 1'b0 || ov_v[g] !== 1'b0 || p_v[g] !== 64'd0) begin
                errors++;
                $display("FAIL in_reset dut%0d got rdy=%b ov=%b p=%0h want 0 0 0",
                         g, rdy_v[g], ov_v[g], p_v[g]);
            end
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < NB; g++) begin
            checks++;
            if (rdy_v[g] !== 1'b1 || ov_v[g] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset dut%0d got rdy=%b ov=%b want 1 0",
                         g, rdy_v[g], ov_v[g]);
            end
        end
    endtask

    task automatic test_directed();
        cur = 0;
        do_op(32'd255, 32'd255, 0, 1'b0);
        cur = 1;
        do_op(32'd13, 32'd200, 0, 1'b0);
        cur = 2;
        do_op(32'd0, 32'd77, 0, 1'b0);
        cur = 2;
        do_op(32'd255, 32'd255, 1, 1'b0);
        cur = 0;
        do_op(32'd3, 32'd5, 10, 1'b0);
    endtask

    task automatic test_busy_ignore();
        cur = 0;
        do_op(32'd7, 32'd9, 0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (rdy_v[cur] !== 1'b1 || ov_v[cur] !== 1'b0) begin
                errors++;
                $display("FAIL single_op dut%0d got rdy=%b ov=%b want 1 0",
                         cur, rdy_v[cur], ov_v[cur]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        cur       = 0;
        in_valid  = 1'b1;
        a_drv     = 32'd200;
        b_drv     = 32'd100;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdy_v[cur] !== 1'b0 || ov_v[cur] !== 1'b0 || p_v[cur] !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset dut%0d got rdy=%b ov=%b p=%0h want 0 0 0",
                     cur, rdy_v[cur], ov_v[cur], p_v[cur]);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdy_v[cur] !== 1'b1 || ov_v[cur] !== 1'b0 || p_v[cur] !== 64'd0) begin
            errors++;
            $display("FAIL after_mid_reset dut%0d got rdy=%b ov=%b p=%0h want 1 0 0",
                     cur, rdy_v[cur], ov_v[cur], p_v[cur]);
        end
        do_op(32'd2, 32'd3, 0, 1'b0);
        // Discard a finished product that is still waiting on out_ready.
        in_valid  = 1'b1;
        a_drv     = 32'd3;
        b_drv     = 32'd5;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        guard    = 0;
        while (guard < 50 && ov_v[cur] !== 1'b1) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        checks++;
        if (ov_v[cur] !== 1'b1) begin
            errors++;
            $display("FAIL reach_done dut%0d got ov=%b want 1", cur, ov_v[cur]);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (ov_v[cur] !== 1'b0 || rdy_v[cur] !== 1'b1) begin
                errors++;
                $display("FAIL done_reset dut%0d got ov=%b rdy=%b want 0 1",
                         cur, ov_v[cur], rdy_v[cur]);
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_random();
        int bp;
        for (int g = 3; g < NB; g++) begin
            cur = g;
            for (int t = 0; t < 1000; t++) begin
                bp = ($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0;
                case (t)
                    0: do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, bp, 1'b0);
                    1: do_op(32'd0, $urandom, bp, 1'b0);
                    2: do_op($urandom, 32'd0, bp, 1'b0);
                    default: do_op($urandom, $urandom, bp, 1'b0);
                endcase
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        @(negedge clk);
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
